// File: rtl/subunit_sched_pkg.sv
// Shared types and helpers for parent-level round-robin sub-unit arbitration.
// rr_pick is a behavioural reference of the rotate-priority scan, for up to 16 requesters.
package subunit_sched_pkg;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} sched_state_e;

    localparam int DEFAULT_NUM_REQ = 5;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
        pick_t r;
        int    k;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= n) k = k - n;
            if (req[k]) begin
                r.vld = 1'b1;
                r.idx = k[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/subunit_rr_pick.sv
// Rotate-priority encoder: first set req bit at or after ptr, wrapping mod NUM_REQ.
// Purely combinational; no flow control of its own.
module subunit_rr_pick #(
    parameter int NUM_REQ = 5,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               vld,
    output logic [ID_W-1:0]    idx
);

    logic [NUM_REQ-1:0] rot;

    // Modular add that works for non-power-of-two NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[ID_W-1:0];
    endfunction

    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[wrap_add(ptr, i)];
        end
    end

    // Scan downwards so the lowest rotated position wins.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                vld = 1'b1;
                idx = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/subunit_rr_scheduler.sv
// Round-robin owner of one shared execution slot; optional forced release under SUBUNIT_SCHED_TIMEOUT_EN.
// Latency: req sampled in IDLE -> grant one cycle later; each grant costs IDLE+GRANT+RELEASE (>=3 cycles).
// Backpressure: no preemption; a grant holds until done, req withdrawal, or (optionally) MAX_HOLD cycles.
module subunit_rr_scheduler
    import subunit_sched_pkg::*;
#(
    parameter int NUM_REQ  = DEFAULT_NUM_REQ,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               spurious_done,
    output logic               timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_param
        $error("subunit_rr_scheduler: NUM_REQ or MAX_HOLD out of legal range");
    end

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(NUM_REQ - 1);

    sched_state_e    state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] pick_idx;
    logic            pick_vld;
    logic            own_done;
    logic            own_req;
    logic            force_rel;
    logic            exit_grant;

    subunit_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign own_done   = done[grant_id];
    assign own_req    = req[grant_id];
    assign exit_grant = own_done | ~own_req | force_rel;
    assign ptr_next   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    assign busy       = (state == S_GRANT);

`ifdef SUBUNIT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    // Held at zero outside GRANT, so every grant starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state != S_GRANT) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign force_rel = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // A release that coincides with done or withdrawal is a normal release, not a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == S_GRANT) & force_rel & own_req & ~own_done;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            grant         <= '0;
            grant_id      <= '0;
            spurious_done <= 1'b0;
        end else begin
            // grant is zero outside GRANT, so any done seen then is also spurious.
            spurious_done <= spurious_done | (|(done & ~grant));
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant    <= ONE_HOT0 << pick_idx;
                        grant_id <= pick_idx;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (exit_grant) begin
                        grant <= '0;
                        ptr   <= ptr_next;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subunit_rr_scheduler.sv
// Directed bench for subunit_rr_scheduler (NUM_REQ=5, MAX_HOLD=8); inputs driven and outputs sampled on negedge.
module tb_subunit_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       spurious_done;
    logic       timeout;

    int n_assert = 0;
    int n_fail   = 0;

    subunit_rr_scheduler #(
        .NUM_REQ  (5),
        .MAX_HOLD (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .done          (done),
        .grant         (grant),
        .grant_id      (grant_id),
        .busy          (busy),
        .spurious_done (spurious_done),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int order [5] = '{0, 2, 4, 0, 2};
        int bad;
        int hi;
        int tp;
        int tpos;

        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        cyc();
        cyc();
        chk("rst_grant", grant, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spurious", spurious_done, 0);
        chk("rst_timeout", timeout, 0);

        // Fairness: 10101 from ptr 0 serves 0,2,4,0,2; each grant is followed by RELEASE then IDLE.
        rst_n = 1'b1;
        req   = 5'b10101;
        for (int r = 0; r < 5; r++) begin
            cyc();
            chk("fair_grant", grant, 32'(1) << order[r]);
            chk("fair_id", grant_id, order[r]);
            chk("fair_busy", busy, 1);
            cyc();
            chk("fair_hold", grant, 32'(1) << order[r]);
            done = 5'(32'(1) << order[r]);
            cyc();
            done = '0;
            chk("fair_release_gap", grant, 0);
            chk("fair_release_busy", busy, 0);
            cyc();
            chk("fair_idle_gap", grant, 0);
        end

        // Pointer wrap: after 4 completes, 00011 must go to 0.
        req = 5'b10000;
        cyc();
        chk("wrap_grant4", grant, 5'b10000);
        chk("wrap_id4", grant_id, 4);
        done = 5'b10000;
        req  = 5'b00000;
        cyc();
        chk("wrap_release", grant, 0);
        done = '0;
        req  = 5'b00011;
        cyc();
        cyc();
        chk("wrap_grant0", grant, 5'b00001);
        chk("wrap_id0", grant_id, 0);
        done = 5'b00001;
        req  = 5'b00000;
        cyc();
        done = '0;
        cyc();

        // Spurious done on a non-granted child is sticky and leaves the grant alone.
        req = 5'b00010;
        cyc();
        chk("spur_grant1", grant, 5'b00010);
        chk("spur_pre", spurious_done, 0);
        done = 5'b01000;
        cyc();
        done = '0;
        chk("spur_set", spurious_done, 1);
        chk("spur_grant_kept", grant, 5'b00010);
        chk("spur_busy_kept", busy, 1);
        cyc();
        chk("spur_sticky", spurious_done, 1);
        chk("spur_grant_kept2", grant, 5'b00010);
        done = 5'b00010;
        req  = 5'b01010;
        cyc();
        done = '0;
        chk("spur_release", grant, 0);

        // Withdrawal: child 3 drops req without done, pending child 1 is served next.
        cyc();
        cyc();
        chk("wd_grant3", grant, 5'b01000);
        chk("wd_id3", grant_id, 3);
        req = 5'b00010;
        cyc();
        chk("wd_release", grant, 0);
        chk("wd_release_busy", busy, 0);
        cyc();
        cyc();
        chk("wd_grant1", grant, 5'b00010);
        chk("wd_id1", grant_id, 1);
        done = 5'b00010;
        req  = 5'b00000;
        cyc();
        done = '0;
        cyc();

        // Hold behaviour: child 0 granted (ptr 2 scans 2,3,4,0) and never signals done.
        req = 5'b00011;
        cyc();
        chk("hold_grant0", grant, 5'b00001);
        chk("hold_id0", grant_id, 0);
`ifdef SUBUNIT_SCHED_TIMEOUT_EN
        hi   = 1;
        tp   = 0;
        tpos = 0;
        for (int i = 2; i <= 10; i++) begin
            cyc();
            if (grant === 5'b00001) hi++;
            if (timeout === 1'b1) begin
                tp++;
                tpos = i;
            end
        end
        chk("to_grant_cycles", hi, 8);
        chk("to_pulse_count", tp, 1);
        chk("to_pulse_cycle", tpos, 9);
        cyc();
        chk("to_next_grant", grant, 5'b00010);
        chk("to_next_id", grant_id, 1);
`else
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            cyc();
            if (grant !== 5'b00001 || timeout !== 1'b0) bad++;
        end
        chk("hold_no_timeout", bad, 0);
        chk("hold_busy", busy, 1);
`endif

        // Asynchronous reset in the middle of a grant.
        chk("pre_reset_spurious", spurious_done, 1);
        req = 5'b11111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_spurious", spurious_done, 0);
        chk("arst_timeout", timeout, 0);
        chk("arst_grant_id", grant_id, 0);
        cyc();
        rst_n = 1'b1;
        req   = 5'b00100;
        cyc();
        chk("post_rst_grant", grant, 5'b00100);
        chk("post_rst_id", grant_id, 2);
        chk("post_rst_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
